// File: rtl/wb_trace_capture_if.sv
// Write-back capture and trace read-port bundle for wb_trace_capture.
// The master side is the core/consumer; the slave side is the trace buffer.
interface wb_trace_capture_if #(
  parameter int unsigned ARQ  = 16,
  parameter int unsigned TS_W = 16
);
  logic            wb_en;
  logic [ARQ-1:0]  wb_data;
  logic            rd_ready;
  logic            rd_valid;
  logic [ARQ-1:0]  rd_data;
  logic [TS_W-1:0] rd_stamp;

  modport master (
    output wb_en, wb_data, rd_ready,
    input  rd_valid, rd_data, rd_stamp
  );

  modport slave (
    input  wb_en, wb_data, rd_ready,
    output rd_valid, rd_data, rd_stamp
  );
endinterface

// File: rtl/wb_trace_capture.sv
// Core reset sequencer plus timestamped write-back trace FIFO with
// capture-all, match-filter, wrap-around and stop-on-full behaviour.
module wb_trace_capture #(
  parameter int unsigned ARQ      = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TS_W     = 16,
  parameter int unsigned RST_HOLD = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  wb_trace_capture_if.slave        bus,
  output logic                     core_rst_o,
  input  logic                     cap_en_i,
  input  logic                     wrap_mode_i,
  input  logic                     match_en_i,
  input  logic [ARQ-1:0]           match_val_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [7:0]               drop_cnt_o,
  output logic [1:0]               state_o
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned HoldW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRun     = 2'd1,
    StStopped = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [7:0]        drop_q, drop_d;

  logic [ARQ-1:0]    mem_data  [DEPTH];
  logic [TS_W-1:0]   mem_stamp [DEPTH];

  logic              push;
  logic              pop;
  logic              wr_en;
  logic              drop_inc;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    ts_d     = ts_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    wr_en    = 1'b0;
    drop_inc = 1'b0;

    // No bypass: pop only sees entries already registered as present.
    pop  = ~empty_q & bus.rd_ready;
    push = (state_q == StRun) & cap_en_i & bus.wb_en &
           (~match_en_i | (bus.wb_data == match_val_i));

    case (state_q)
      StHold: begin
        if (hold_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRun: begin
        ts_d = ts_q + 1'b1;
      end
      StStopped: begin
        ts_d = ts_q + 1'b1;
        if (!cap_en_i && !full_q) begin
          state_d = StRun;
        end
      end
      default: state_d = StHold;
    endcase

    if (push) begin
      if (pop) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + 1'b1;
        rptr_d = rptr_q + 1'b1;
      end else if (!full_q) begin
        wr_en   = 1'b1;
        wptr_d  = wptr_q + 1'b1;
        count_d = count_q + 1'b1;
      end else if (wrap_mode_i) begin
        // Full: wptr == rptr, so the write lands on the oldest entry.
        wr_en    = 1'b1;
        wptr_d   = wptr_q + 1'b1;
        rptr_d   = rptr_q + 1'b1;
        drop_inc = 1'b1;
      end else begin
        drop_inc = 1'b1;
        state_d  = StStopped;
      end
    end else if (pop) begin
      rptr_d  = rptr_q + 1'b1;
      count_d = count_q - 1'b1;
    end

    if (drop_inc && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 1'b1;
    end

    full_d  = (count_d == CntFull);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StHold;
      hold_q  <= '0;
      ts_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ts_q    <= ts_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is deliberately not reset; count_q == 0 makes it unreachable.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_data[wptr_q]  <= bus.wb_data;
      mem_stamp[wptr_q] <= ts_q;
    end
  end

  assign core_rst_o   = (state_q == StHold);
  assign state_o      = state_q;
  assign count_o      = count_q;
  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign drop_cnt_o   = drop_q;
  assign bus.rd_valid = ~empty_q;
  assign bus.rd_data  = empty_q ? '0 : mem_data[rptr_q];
  assign bus.rd_stamp = empty_q ? '0 : mem_stamp[rptr_q];

endmodule

// File: doc/wb_trace_capture.md
# wb_trace_capture

Synthesizable reset sequencer and write-back trace buffer for the 16-bit ASIP core. It holds the core in reset for a programmable number of cycles after system reset releases, then timestamps and buffers core write-back results in a FIFO. The FIFO supports capture-all, match-filtered, wrap-around and stop-on-full modes. A valid/ready read port drains the buffer for on-chip debug or bench checking, replacing ad-hoc observation of `result_WB` at the top level.

## Interface
- `ARQ`, 16, data width of write-back results
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `TS_W`, 16, timestamp width
- `RST_HOLD`, 10, cycles `core_rst` stays asserted after `rst` releases; ≥ 1
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `core_rst`  out  1  active-high reset to core (drives core `rst` and `rst_ALU`)
- `wb_en_in`  in  1  core write-back enable
- `wb_data_in`  in  ARQ  core write-back result
- `cap_en`  in  1  capture enable
- `wrap_mode`  in  1  1 = overwrite oldest when full; 0 = stop on full
- `match_en`  in  1  1 = capture only when `wb_data_in == match_val`
- `match_val`  in  ARQ  filter compare value
- `rd_ready`  in  1  consumer ready
- `rd_valid`  out  1  head entry valid (= !empty)
- `rd_data`  out  ARQ  head result; 0 when empty
- `rd_stamp`  out  TS_W  head timestamp; 0 when empty
- `count`  out  $clog2(DEPTH)+1  entries held
- `full`, `empty`  out  1  FIFO flags
- `drop_cnt`  out  8  dropped/overwritten entries, saturates at 255
- `state`  out  2  0 = HOLD, 1 = RUN, 2 = STOPPED

## Operation
- **Reset values** (while `rst` = 0):
  - `core_rst` = 1, `state` = HOLD
  - `count` = 0, `empty` = 1, `full` = 0
  - `rd_valid` = 0, `rd_data` = 0, `rd_stamp` = 0
  - `drop_cnt` = 0, timestamp = 0, pointers = 0
- **HOLD:**
  - Hold counter counts edges after `rst` rises.
  - `core_rst` deasserts on the edge that completes `RST_HOLD` cycles; `state` → RUN on that same edge.
  - No capture in HOLD.
- **RUN:**
  - Timestamp counter increments every cycle and wraps modulo 2^TS_W. The first RUN cycle carries stamp 0.
  - Capture condition = `cap_en & wb_en_in & (!match_en | wb_data_in == match_val)`.
  - On capture, `{timestamp, wb_data_in}` is written at the write pointer.
- **Full handling when capture occurs:**
  - Pop in same cycle, any mode: push and pop both happen; `count` unchanged; no drop.
  - No pop, `wrap_mode` = 1: oldest entry discarded (read pointer advances); `count` stays `DEPTH`; `drop_cnt` += 1.
  - No pop, `wrap_mode` = 0: new entry discarded; `drop_cnt` += 1; `state` → STOPPED.
- **STOPPED:**
  - No capture; the timestamp keeps counting.
  - Returns to RUN on the first edge where `cap_en` = 0 and `full` = 0.
- **Read port:** first-word-fall-through. A pop occurs when `rd_valid & rd_ready`; the read pointer advances at that edge.
- **Pointers:** wrap modulo `DEPTH`. `count` tracks occupancy exactly (push only +1, pop only −1, both 0).
- **Reset mid-operation:** asynchronous return to all reset values. FIFO contents are not cleared but are unreachable because `count` = 0. HOLD restarts from zero.

## Timing
- **Capture latency:** entry captured at edge N is visible on `rd_valid`/`rd_data` after edge N, in the same cycle as `count` updates.
- **Flags:** `full`, `empty`, `count` and `drop_cnt` are registered and update on the same edge as the push/pop.
- **Read outputs:** `rd_data`/`rd_stamp` are combinational from storage at the read pointer, gated to 0 when empty.
- **Reset assertion:** asynchronous; all outputs take reset values immediately.
- **Reset release:** synchronous to the first rising `clk` edge with `rst` = 1.
- **Simultaneous events:**
  - Pop on an empty FIFO is ignored.
  - Push to empty with `rd_ready` = 1: the entry is not popped that cycle (no bypass).

## Test plan
- `rst` low for 3 cycles, release with `RST_HOLD` = 10 → `core_rst` = 1 for exactly 10 edges, then 0 with `state` = 1; first captured entry has stamp 0 if `wb_en_in` is high on the first RUN cycle.
- Capture-all, `rd_ready` = 0, push 0x0001..0x0005 on consecutive cycles → `count` = 5; drain with `rd_ready` = 1 → data 0x0001..0x0005, consecutive stamps, then `empty` = 1.
- `wrap_mode` = 1, push 20 values 0x0100..0x0113 with no reads (`DEPTH` = 16) → `count` = 16, `drop_cnt` = 4, head = 0x0104.
- `wrap_mode` = 0, push 17 values with no reads → 17th dropped, `drop_cnt` = 1, `state` = 2; read 1 entry, drop `cap_en` for one cycle → `state` = 1.
- `match_en` = 1, `match_val` = 0xBEEF, write-back stream 0x0000, 0xBEEF, 0x1234, 0xBEEF → `count` = 2, both entries 0xBEEF with correct stamps.
- Full FIFO, simultaneous capture and `rd_ready` = 1 → `count` stays 16, `drop_cnt` unchanged; then assert `rst` low mid-stream → all outputs return to reset values within the same cycle.
